data_mem_resp: RTL

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
//   Wait-stated data memory behind the MEM pipeline stage. A request is
//   captured in IDLE. The FSM spends WAIT_CYC cycles in BUSY and then spends
//   one cycle in RESP. On the edge into RESP a write updates the array, or a
//   read loads rd_data. done pulses for the RESP cycle. stall holds the
//   pipeline from the first request cycle until RESP.
//
//   Optional feature: define DM_ADDR_CHK_EN to add the err port. With it,
//   an access whose addr[15:ADDR_W] is nonzero still completes with normal
//   latency, but it pulses err together with done. Its write is dropped, and
//   a read returns 16'h0000. Without it, the upper address bits are ignored
//   and addresses alias modulo 2^ADDR_W.
// -----------------------------------------------------------------------------
module data_mem_resp #(
    parameter int WAIT_CYC = 2,   // wait states per access, 0..15
    parameter int ADDR_W   = 10   // word-address width of the internal array
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        stall,
    output logic        done
`ifdef DM_ADDR_CHK_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;

    // Request captured in IDLE, used for the rest of the access
    logic                op_wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         data_q;

    logic [15:0]         rd_data_q, rd_data_d;
    logic [15:0]         mem_q [DEPTH];

    logic                req;
    logic                capture;
    logic                commit;
    logic                acc_wr;
    logic                acc_bad;
    logic [ADDR_W-1:0]   acc_addr;
    logic [15:0]         acc_data;
    logic                mem_we;

    assign req     = re | we;
    assign capture = (state_q == IDLE) && req;

`ifdef DM_ADDR_CHK_EN
    logic bad_q;
    logic addr_hi_bad;

    assign addr_hi_bad = |addr[15:ADDR_W];
    // The out-of-range flag comes from the live address in IDLE
    // (WAIT_CYC=0 case) and from the captured flag afterwards
    assign acc_bad     = (state_q == IDLE) ? addr_hi_bad : bad_q;
`else
    logic unused_addr_hi;

    // The upper address bits are intentionally ignored, so addresses alias
    assign unused_addr_hi = ^addr[15:ADDR_W];
    assign acc_bad        = 1'b0;
`endif

    // FSM state register and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: use non-blocking assignments for every register so that all
        // flops update together from values sampled before the edge.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic: IDLE -> (BUSY ->) RESP -> IDLE
    always_comb begin
        // NOTE: assign defaults first so that every path drives every
        // signal; otherwise a latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYC == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Requests seen here belong to the instruction being released
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: hold the pipeline until the response cycle
    always_comb begin
        stall = ((state_q == IDLE) && req) || (state_q == BUSY);
        done  = (state_q == RESP);
`ifdef DM_ADDR_CHK_EN
        err   = (state_q == RESP) && bad_q;
`endif
    end

    // Capture the operation, address and write data when a request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= 16'h0000;
`ifdef DM_ADDR_CHK_EN
            bad_q   <= 1'b0;
`endif
        end else if (capture) begin
            op_wr_q <= we;
            addr_q  <= addr[ADDR_W-1:0];
            data_q  <= wrt_data;
`ifdef DM_ADDR_CHK_EN
            bad_q   <= addr_hi_bad;
`endif
        end
    end

    // Access operands: use the live inputs on the capture edge (so that
    // WAIT_CYC=0 works), and use the captured copy after that edge
    always_comb begin
        if (state_q == IDLE) begin
            acc_wr   = we;
            acc_addr = addr[ADDR_W-1:0];
            acc_data = wrt_data;
        end else begin
            acc_wr   = op_wr_q;
            acc_addr = addr_q;
            acc_data = data_q;
        end
    end

    // The access takes effect on the edge that enters RESP
    assign commit = (state_q != RESP) && (state_d == RESP);
    assign mem_we = commit && acc_wr && !acc_bad;

    // Storage array write port
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset. Resetting it would turn the
        // RAM into thousands of flops, and its contents are undefined until
        // written anyway.
        if (mem_we) begin
            mem_q[acc_addr] <= acc_data;
        end
    end

    // Read data: a completed read loads it; a write leaves it unchanged
    always_comb begin
        rd_data_d = rd_data_q;
        if (commit && !acc_wr) begin
            rd_data_d = acc_bad ? 16'h0000 : mem_q[acc_addr];
        end
    end

    // Read data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 16'h0000;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule
